// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants and FSM state encoding for the rotor scheduler
package enigma_pkg;
  localparam int ALPHA_SIZE = 26;
  localparam int NOTCH_POS = 25;
  localparam int POS_W = 5;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_OUT = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SHIFT = ST_SHIFT,
    STEP = ST_STEP,
    OUT = ST_OUT
  } state_t;
endpackage

// File: rtl/enigma_rotor_scheduler_rotor_odometer.sv
// rotor_odometer: rotor position registers, load port and odometer stepping (ROTOR_DOUBLE_STEP_EN adds middle-rotor double-step)
module rotor_odometer
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          load_en,
  input  logic [1:0]                    load_idx,
  input  logic [4:0]                    load_val,
  input  logic                          step,
  output logic [POS_W*NUM_ROTORS-1:0]   pos
);
  logic [NUM_ROTORS-1:0] wrap;
  logic [NUM_ROTORS-1:0] notch;
  logic [NUM_ROTORS-1:0] adv;
  logic carry;
  // per-rotor flags taken from pre-step positions
  always_comb begin
    wrap = '0;
    notch = '0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      wrap[i] = pos[POS_W*i +: POS_W] == POS_W'(ALPHA_SIZE - 1);
      notch[i] = pos[POS_W*i +: POS_W] == POS_W'(NOTCH_POS);
    end
  end
  // carry chain: a rotor advances when every lower rotor wraps this step
  always_comb begin
    carry = 1'b1;
    adv = '0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      adv[i] = carry;
      carry = carry && wrap[i];
`ifdef ROTOR_DOUBLE_STEP_EN
      if (i == 0 && NUM_ROTORS >= 3) carry = wrap[0] || notch[NUM_ROTORS > 1 ? 1 : 0];
`endif
    end
  end
  // positions: reset, step from pre-step values, or guarded load
  always_ff @(posedge clk) begin
    if (!resetn) pos <= '0;
    else if (step) begin
      for (int i = 0; i < NUM_ROTORS; i++)
        if (adv[i]) pos[POS_W*i +: POS_W] <= wrap[i] ? '0 : pos[POS_W*i +: POS_W] + 5'd1;
    end else if (load_en && 32'(load_idx) < NUM_ROTORS && load_val < 5'(ALPHA_SIZE))
      pos[POS_W*load_idx +: POS_W] <= load_val;
  end
endmodule

// File: rtl/enigma_rotor_scheduler.sv
// enigma_rotor_scheduler: per-letter sequencer sharing one shifter across rotor stages (ROTOR_DOUBLE_STEP_EN selects double-step)
module enigma_rotor_scheduler
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [6:0]                  in_char,
  input  logic                        encrypt,
  input  logic                        load_en,
  input  logic [1:0]                  load_idx,
  input  logic [4:0]                  load_val,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_char,
  output logic [6:0]                  shf_char,
  output logic [7:0]                  shf_rotor,
  output logic                        shf_encrypt,
  input  logic [7:0]                  shf_result,
  output logic [POS_W*NUM_ROTORS-1:0] rotor_pos
);
  localparam logic [1:0] K_LAST = 2'(NUM_ROTORS - 1);
  state_t state, state_d;
  logic [6:0] work;
  logic [1:0] k;
  logic mode;
  logic pass;
  logic [POS_W-1:0] pos_k;
  logic unused_bits;
  assign unused_bits = shf_result[7];
  assign pos_k = rotor_pos[POS_W*k +: POS_W];
  assign in_ready = state == IDLE;
  assign out_valid = state == OUT;
  assign out_char = {1'b0, work};
  assign shf_char = state == SHIFT ? work : '0;
  assign shf_rotor = state == SHIFT ? {3'b0, pos_k} : '0;
  assign shf_encrypt = state == SHIFT && mode;
  rotor_odometer #(.NUM_ROTORS(NUM_ROTORS)) u_odo (
    .clk(clk),
    .resetn(resetn),
    .load_en(load_en && state == IDLE && !in_valid),
    .load_idx(load_idx),
    .load_val(load_val),
    .step(state == STEP && !pass),
    .pos(rotor_pos)
  );
  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else state <= state_d;
  end
  // next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = in_valid ? SHIFT : IDLE;
      SHIFT: state_d = k == K_LAST ? STEP : SHIFT;
      STEP: state_d = OUT;
      default: state_d = out_ready ? IDLE : OUT;
    endcase
  end
  // work register, mode, pass-through flag and stage counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      work <= '0;
      k <= '0;
      mode <= 1'b0;
      pass <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      work <= in_char;
      mode <= encrypt;
      pass <= in_char >= 7'(ALPHA_SIZE);
      k <= '0;
    end else if (state == SHIFT) begin
      if (!pass) work <= shf_result[6:0];
      k <= k + 2'd1;
    end
  end
endmodule

// File: tb/tb_enigma_rotor_scheduler.sv
// tb_enigma_rotor_scheduler: directed self-checking bench with a modular letter-shifter model
module tb_enigma_rotor_scheduler;
  logic clk = 1'b0;
  logic resetn, in_valid, in_ready, encrypt, load_en, out_valid, out_ready, shf_encrypt;
  logic [6:0] in_char, shf_char;
  logic [1:0] load_idx;
  logic [4:0] load_val;
  logic [7:0] out_char, shf_rotor, shf_result;
  logic [14:0] rotor_pos;
  int n_checks = 0;
  int n_fail = 0;

  enigma_rotor_scheduler #(.NUM_ROTORS(3)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .encrypt(encrypt), .load_en(load_en), .load_idx(load_idx),
    .load_val(load_val), .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .shf_char(shf_char), .shf_rotor(shf_rotor),
    .shf_encrypt(shf_encrypt), .shf_result(shf_result), .rotor_pos(rotor_pos)
  );

  always #5 clk = ~clk;

  // shifter: (char + rotor) mod 26 when encrypting, (char - rotor) mod 26 otherwise
  always_comb begin
    shf_result = shf_encrypt ? 8'((int'(shf_char) + int'(shf_rotor)) % 26)
                             : 8'((int'(shf_char) + 26 - int'(shf_rotor) % 26) % 26);
  end

  function automatic logic [14:0] p3(input int a, input int b, input int c);
    return 15'(a | (b << 5) | (c << 10));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input int val);
    load_en = 1'b1;
    load_idx = 2'(idx);
    load_val = 5'(val);
    tick;
    load_en = 1'b0;
  endtask

  task automatic send(input string tag, input int ch, input bit enc, input int r0, input int exp_char, input logic [14:0] exp_pos);
    int n;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_char = 7'(ch);
    encrypt = enc;
    tick;
    in_valid = 1'b0;
    in_char = 7'd0;
    check({tag, "_shf_char"}, 32'(shf_char), 32'(ch));
    check({tag, "_shf_rotor"}, 32'(shf_rotor), 32'(r0));
    check({tag, "_shf_enc"}, 32'(shf_encrypt), 32'(enc));
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_out_char"}, 32'(out_char), 32'(exp_char));
    check({tag, "_pos"}, 32'(rotor_pos), 32'(exp_pos));
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    tick;
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
    check({tag, "_ov_low"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0;
    in_char = 7'd0;
    encrypt = 1'b1;
    load_en = 1'b0;
    load_idx = 2'd0;
    load_val = 5'd0;
    out_ready = 1'b1;
    tick;
    tick;
    resetn = 1'b1;
    tick;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_char", 32'(out_char), 32'd0);
    check("rst_pos", 32'(rotor_pos), 32'd0);
    check("rst_shf_char", 32'(shf_char), 32'd0);
    check("rst_shf_rotor", 32'(shf_rotor), 32'd0);
    send("l1", 0, 1'b1, 0, 0, p3(1, 0, 0));
    finish_out("l1");
    send("l2", 0, 1'b1, 1, 1, p3(2, 0, 0));
    finish_out("l2");
    load(0, 25);
    send("wrap_enc", 3, 1'b1, 25, 2, p3(0, 1, 0));
    finish_out("wrap_enc");
    load(0, 25);
    load(1, 0);
    send("wrap_dec", 2, 1'b0, 25, 3, p3(0, 1, 0));
    finish_out("wrap_dec");
    load(0, 5);
    load(1, 25);
    load(2, 0);
`ifdef ROTOR_DOUBLE_STEP_EN
    send("dstep", 0, 1'b1, 5, 4, p3(6, 0, 1));
`else
    send("dstep", 0, 1'b1, 5, 4, p3(6, 25, 0));
`endif
    finish_out("dstep");
    load(0, 7);
    load(1, 3);
    load(2, 1);
    load(2, 26);
    load(3, 4);
    check("bad_load", 32'(rotor_pos), 32'(p3(7, 3, 1)));
    load_en = 1'b1;
    load_idx = 2'd0;
    load_val = 5'd9;
    send("pass", 30, 1'b1, 7, 30, p3(7, 3, 1));
    load_en = 1'b0;
    finish_out("pass");
    out_ready = 1'b0;
    send("stall", 1, 1'b1, 7, 12, p3(8, 3, 1));
    for (int i = 0; i < 5; i++) begin
      load_en = 1'b1;
      load_idx = 2'd1;
      load_val = 5'd20;
      tick;
      check("stall_char", 32'(out_char), 32'd12);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    load_en = 1'b0;
    check("stall_pos", 32'(rotor_pos), 32'(p3(8, 3, 1)));
    finish_out("stall");
    in_valid = 1'b1;
    in_char = 7'd5;
    tick;
    in_valid = 1'b0;
    tick;
    check("mid_shift_busy", 32'(in_ready), 32'd0);
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    check("midrst_idle", 32'(in_ready), 32'd1);
    check("midrst_ov", 32'(out_valid), 32'd0);
    check("midrst_pos", 32'(rotor_pos), 32'd0);
    check("midrst_char", 32'(out_char), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick;
      check("midrst_no_out", 32'(out_valid), 32'd0);
    end
    send("post_rst", 25, 1'b1, 0, 25, p3(1, 0, 0));
    finish_out("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
